flaf_stream_ctrl: RTL

//  On-chip stimulus/capture sequencer for the HBO-TFLAF filter core. It replays
//  x/d sample pairs from a sample ROM into the filter's signal_in/desired_in and

---
 rtl/flaf_stream_ctrl_if.sv | 32 +++
 rtl/flaf_stream_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/flaf_stream_ctrl_if.sv
// rtl/flaf_stream_ctrl_if.sv - sequencer bus: run control, sample ROM, filter drive and capture RAM
interface flaf_stream_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) ();
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] smp_addr;
    logic [WIDTH-1:0]  smp_x_in;
    logic [WIDTH-1:0]  smp_d_in;
    logic              filt_reset;
    logic [WIDTH-1:0]  signal_out;
    logic [WIDTH-1:0]  desired_out;
    logic [WIDTH-1:0]  error_in;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [WIDTH-1:0]  cap_data;

    // master is the sequencer, slave is the memory/filter environment around it
    modport master (
        input  start, abort, smp_x_in, smp_d_in, error_in,
        output busy, done, smp_addr, filt_reset, signal_out, desired_out,
               cap_we, cap_addr, cap_data
    );
    modport slave (
        output start, abort, smp_x_in, smp_d_in, error_in,
        input  busy, done, smp_addr, filt_reset, signal_out, desired_out,
               cap_we, cap_addr, cap_data
    );
endinterface

// File: rtl/flaf_stream_ctrl.sv
// rtl/flaf_stream_ctrl.sv - replays ROM samples into the filter and captures latency-aligned error words
module flaf_stream_ctrl #(
    parameter int WIDTH  = 16,
    parameter int N      = 25000,
    parameter int ADDR_W = 15,
    parameter int RET    = 6
) (
    input  logic              clk,
    input  logic              reset,
    flaf_stream_ctrl_if.master bus
);
    // One counter covers PRIME (0..1) and then the RUN+FLUSH cycle index c.
    localparam int CW = $clog2(N + RET + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    int            cnt_i;
    logic          active;

    assign cnt_i = int'(cnt_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        active          = (state_q == S_RUN) || (state_q == S_FLUSH);
        bus.busy        = active || (state_q == S_PRIME);
        bus.done        = (state_q == S_DONE);
        bus.filt_reset  = !active;
        bus.signal_out  = active ? bus.smp_x_in : {WIDTH{1'b0}};
        bus.desired_out = active ? bus.smp_d_in : {WIDTH{1'b0}};
        bus.smp_addr    = '0;
        bus.cap_we      = active && (cnt_i >= RET);
        bus.cap_addr    = '0;
        bus.cap_data    = bus.error_in;

        // ROM read is registered, so the address runs one sample ahead of the data
        if (state_q == S_RUN) begin
            bus.smp_addr = ADDR_W'((cnt_i >= N - 1) ? N - 1 : cnt_i + 1);
        end else if (state_q == S_FLUSH) begin
            bus.smp_addr = ADDR_W'(N - 1);
        end
        if (bus.cap_we) begin
            bus.cap_addr = ADDR_W'(cnt_i - RET);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PRIME;
                    cnt_d   = '0;
                end
            end
            S_PRIME: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_i == 1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN, S_FLUSH: begin
                // abort wins over completion on the same edge
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_i >= N + RET - 1) begin
                    state_d = S_DONE;
                end else begin
                    if (cnt_i == N - 1) begin
                        state_d = S_FLUSH;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule
